// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp16 multiplier between two requesters, with credit-checked result FIFOs.
// Define FP16_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of alternating.
module fp16_mul_arbiter #(
    parameter int MUL_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_out,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic                   rst_q;
    logic                   hold;
    logic [1:0]             req_valid;
    logic [1:0]             rsp_ready;
    logic [1:0]             rsp_valid;
    logic [1:0]             elig;
    logic [1:0]             grant;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [CW-1:0]          fifo_cnt [2];
    logic [CW-1:0]          inflight [2];
    logic [PW-1:0]          wr_ptr   [2];
    logic [PW-1:0]          rd_ptr   [2];
    logic [15:0]            mem      [2][FIFO_DEPTH];
    logic [MUL_LATENCY-1:0] tag_valid;
    logic [MUL_LATENCY-1:0] tag_id;
    logic                   exit_valid;
    logic                   exit_id;

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_ready  = {rsp1_ready, rsp0_ready};
    // Outputs stay quiet for the reset cycle and the one after it.
    assign hold       = rst | rst_q;
    assign exit_valid = tag_valid[MUL_LATENCY-1];
    assign exit_id    = tag_id[MUL_LATENCY-1];
    assign push       = {exit_valid & exit_id, exit_valid & ~exit_id};

    always_comb begin
        elig      = 2'b00;
        rsp_valid = 2'b00;
        pop       = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n]      = req_valid[n] && !hold &&
                           (({1'b0, fifo_cnt[n]} + {1'b0, inflight[n]}) < DEPTH_W);
            rsp_valid[n] = (fifo_cnt[n] != '0) && !hold;
            pop[n]       = rsp_valid[n] && rsp_ready[n];
        end
    end

`ifdef FP16_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = 2'b00;
        if (elig[0])
            grant = 2'b01;
        else if (elig[1])
            grant = 2'b10;
    end
`else
    logic last_grant;

    // On a tie, the requester that did not win the last accepted request goes next.
    always_comb begin
        grant = 2'b00;
        if (elig[0] && elig[1])
            grant = last_grant ? 2'b01 : 2'b10;
        else if (elig[0])
            grant = 2'b01;
        else if (elig[1])
            grant = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end
`endif

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign mul_a      = grant[0] ? req0_a : (grant[1] ? req1_a : 16'h0000);
    assign mul_b      = grant[0] ? req0_b : (grant[1] ? req1_b : 16'h0000);
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = mem[0][rd_ptr[0]];
    assign rsp1_data  = mem[1][rd_ptr[1]];
    assign busy       = !hold && ((|tag_valid) || (fifo_cnt[0] != '0) || (fifo_cnt[1] != '0));

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Tags shadow the multiplier pipeline so each product lands in its requester's FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
            for (int n = 0; n < 2; n++) begin
                fifo_cnt[n] <= '0;
                inflight[n] <= '0;
                wr_ptr[n]   <= '0;
                rd_ptr[n]   <= '0;
            end
        end else begin
            for (int i = MUL_LATENCY - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            tag_valid[0] <= |grant;
            tag_id[0]    <= grant[1];
            for (int n = 0; n < 2; n++) begin
                case ({grant[n], push[n]})
                    2'b10:   inflight[n] <= inflight[n] + CW'(1);
                    2'b01:   inflight[n] <= inflight[n] - CW'(1);
                    default: inflight[n] <= inflight[n];
                endcase
                case ({push[n], pop[n]})
                    2'b10:   fifo_cnt[n] <= fifo_cnt[n] + CW'(1);
                    2'b01:   fifo_cnt[n] <= fifo_cnt[n] - CW'(1);
                    default: fifo_cnt[n] <= fifo_cnt[n];
                endcase
                if (push[n])
                    wr_ptr[n] <= wr_ptr[n] + PW'(1);
                if (pop[n])
                    rd_ptr[n] <= rd_ptr[n] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (exit_valid)
            mem[exit_id][wr_ptr[exit_id]] <= mul_out;
    end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a 5-stage table-driven multiplier stand-in.
// Build with FP16_ARB_FIXED_PRIORITY_EN defined to exercise the fixed-priority variant.
module tb_fp16_mul_arbiter;
    localparam int LAT = 5;
`ifdef FP16_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [15:0] rsp0_data, rsp1_data;
    logic [15:0] mul_a, mul_b, mul_out;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          valIdx = 0;
    int          acc, acc0, acc1, first1, n0, n1;
    logic [15:0] vals [12];
    logic [15:0] expQ [$];
    logic [15:0] mulPipe [LAT];

    always #5 clk = ~clk;

    fp16_mul_arbiter #(.MUL_LATENCY(LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .busy(busy)
    );

    // Products only for the operand pairs this bench issues.
    function automatic logic [15:0] mulModel(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00) return b;
        if (b == 16'h3C00) return a;
        if (a == 16'h3E00 && b == 16'h4000) return 16'h4200;
        if (a[14:10] == 5'h1F && b[14:0] == 15'h0) return 16'h7E00;
        return 16'h0000;
    endfunction

    always @(posedge clk) begin
        mulPipe[0] <= mulModel(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
    end
    assign mul_out = mulPipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic doReset();
        nextCycle();
        rst = 1'b1;
        clearInputs();
        nextCycle();
        nextCycle();
        rst = 1'b0;
        valIdx = 0;
        expQ.delete();
    endtask

    // Requester 0 issues 1.0 * vals[k]; popped results must match issue order.
    task automatic applyStimulus(input int cycles, input bit drive, input bit drain, output int accepts);
        accepts = 0;
        for (int i = 0; i < cycles; i++) begin
            nextCycle();
            req0_valid = drive;
            req0_a     = 16'h3C00;
            req0_b     = vals[valIdx % 12];
            rsp0_ready = drain;
            #2;
            if (rsp0_valid && expQ.size() == 0)
                checkOutput("rsp0_extra", rsp0_valid, 0);
            else if (rsp0_valid && drain)
                checkOutput("rsp0_order", rsp0_data, expQ.pop_front());
            else if (rsp0_valid)
                checkOutput("rsp0_hold", rsp0_data, expQ[0]);
            if (req0_ready) begin
                expQ.push_back(vals[valIdx % 12]);
                valIdx++;
                accepts++;
            end
        end
    endtask

    // Both requesters offer the 1.5*2.0 and inf*0 pairs; consumers follow the drain flag.
    task automatic driveBoth(input bit drive, input bit drain);
        req0_valid = drive; req0_a = 16'h3E00; req0_b = 16'h4000;
        req1_valid = drive; req1_a = 16'h7C00; req1_b = 16'h0000;
        rsp0_ready = drain; rsp1_ready = drain;
    endtask

    task automatic countRsp();
        if (rsp0_valid && rsp0_ready) begin
            checkOutput("rsp0_prod", rsp0_data, 16'h4200);
            n0++;
        end
        if (rsp1_valid && rsp1_ready) begin
            checkOutput("rsp1_nan", rsp1_data, 16'h7E00);
            n1++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vals = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
                 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80};

        // Reset cycle and the cycle after it: nothing may be offered or reported.
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h4000;
        nextCycle(); #2;
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp0", rsp0_valid, 0);
        nextCycle();
        rst = 1'b0;
        #2;
        checkOutput("post_rst_ready0", req0_ready, 0);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_rsp1", rsp1_valid, 0);

        // Single 1.0*2.0 request: result visible six cycles after accept.
        nextCycle();
        rsp0_ready = 1'b1;
        #2;
        checkOutput("single_ready0", req0_ready, 1);
        checkOutput("single_mul_a", mul_a, 16'h3C00);
        checkOutput("single_mul_b", mul_b, 16'h4000);
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            req0_valid = 1'b0;
            #2;
            checkOutput($sformatf("single_rsp0_valid_c%0d", k), rsp0_valid, (k == 6));
            if (k == 1) checkOutput("idle_mul_a", mul_a, 16'h0000);
            if (k == 3) checkOutput("single_busy", busy, 1);
            if (k == 6) checkOutput("single_data", rsp0_data, 16'h4000);
        end
        checkOutput("single_idle", busy, 0);

        // Saturated pipeline with consumers always ready.
        doReset();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            driveBoth(1'b1, 1'b1);
            #2;
            checkOutput($sformatf("rr_ready0_%0d", i), req0_ready, FIXED ? 1'b1 : (i % 2 == 0));
            checkOutput($sformatf("rr_ready1_%0d", i), req1_ready, FIXED ? 1'b0 : (i % 2 == 1));
            if (req1_ready) checkOutput("rr_mul_a1", mul_a, 16'h7C00);
            countRsp();
        end
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            driveBoth(1'b0, 1'b1);
            #2;
            countRsp();
        end
        checkOutput("rr_count0", n0, FIXED ? 12 : 6);
        checkOutput("rr_count1", n1, FIXED ? 0 : 6);
        checkOutput("rr_idle", busy, 0);

        // Credit exhaustion: exactly eight accepts, one more after a single pop.
        doReset();
        applyStimulus(20, 1'b1, 1'b0, acc);
        checkOutput("fill_accepts", acc, 8);
        checkOutput("fill_ready0_low", req0_ready, 0);
        applyStimulus(1, 1'b1, 1'b1, acc);
        checkOutput("pop_no_accept", acc, 0);
        applyStimulus(15, 1'b1, 1'b0, acc);
        checkOutput("refill_accepts", acc, 1);
        applyStimulus(25, 1'b0, 1'b1, acc);
        checkOutput("fill_drained", expQ.size(), 0);

        // Write and pop in the same cycle while three results are queued.
        doReset();
        applyStimulus(4, 1'b1, 1'b0, acc);
        checkOutput("wp_issue", acc, 4);
        applyStimulus(4, 1'b0, 1'b0, acc);
        applyStimulus(1, 1'b0, 1'b1, acc);
        applyStimulus(15, 1'b1, 1'b0, acc);
        checkOutput("wp_credit", acc, 5);
        applyStimulus(25, 1'b0, 1'b1, acc);
        checkOutput("wp_drained", expQ.size(), 0);

        // Reset with four operations in flight discards them.
        doReset();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            driveBoth(1'b1, 1'b1);
            #2;
            acc += int'(req0_ready) + int'(req1_ready);
        end
        checkOutput("flight_accepts", acc, 4);
        checkOutput("flight_busy", busy, 1);
        nextCycle();
        rst = 1'b1;
        clearInputs();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            rst = 1'b0;
            #2;
            checkOutput($sformatf("flush_rsp0_%0d", i), rsp0_valid, 0);
            checkOutput($sformatf("flush_rsp1_%0d", i), rsp1_valid, 0);
            checkOutput($sformatf("flush_busy_%0d", i), busy, 0);
        end

        // Both requesters valid with stalled consumers until all credit is used.
        doReset();
        acc0 = 0; acc1 = 0; first1 = -1;
        for (int i = 0; i < 30; i++) begin
            nextCycle();
            driveBoth(1'b1, 1'b0);
            #2;
            if (req1_ready && first1 < 0) first1 = acc0;
            if (req0_ready) acc0++;
            if (req1_ready) acc1++;
        end
        checkOutput("prio_first1", first1, FIXED ? 8 : 1);
        checkOutput("prio_acc0", acc0, 8);
        checkOutput("prio_acc1", acc1, 8);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 25; i++) begin
            nextCycle();
            driveBoth(1'b0, 1'b1);
            #2;
            countRsp();
        end
        checkOutput("prio_count0", n0, 8);
        checkOutput("prio_count1", n1, 8);
        checkOutput("prio_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_mul_arbiter.md
FP16_MUL_ARBITER -- requirements
Module: fp16_mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5: register stages in the attached fp16_multiplier, counted from its input register to its output register.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2: result FIFO entries per requester.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1: operand pair offered by requester 0 / 1.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16: fp16 operands.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1: operand pair accepted this cycle.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1: result available; rsp0_ready / rsp1_ready  input  1: consumer takes it.
REQ-009 SHALL have ports rsp0_data / rsp1_data  output  16: fp16 product.
REQ-010 SHALL have ports mul_a, mul_b  output  16 (to multiplier a, b) and mul_out  input  16 (from multiplier out).
REQ-011 SHALL have port busy  output  1: any operation in flight or any FIFO non-empty.

Function
REQ-012 SHALL accept at most one request per cycle; a request is accepted when reqN_valid and reqN_ready are both high.
REQ-013 SHALL assert reqN_ready combinationally only when requester N is granted, and only when credit(N) > 0.
REQ-014 SHALL define credit(N) = FIFO_DEPTH - fifo_count(N) - inflight(N); the FIFO therefore never overflows, since the multiplier cannot stall.
REQ-015 SHALL grant a lone eligible requester; when both are eligible, SHALL grant the one not granted last (round robin).
REQ-016 SHALL update the last-grant pointer only on an accepted request.
REQ-017 SHALL drive mul_a/mul_b combinationally from the granted requester's operands, and SHALL drive 16'h0000 when no grant.
REQ-018 SHALL carry a {valid, id} tag through a MUL_LATENCY-deep shift register, entered at the accept edge.
REQ-019 SHALL, in the cycle the tag exits, write mul_out into FIFO[id]; with MUL_LATENCY=5, an accept in cycle C writes at the end of C+5, and rspN_valid rises in C+6 if the FIFO was empty.
REQ-020 SHALL increment inflight(N) on accept and decrement it on tag exit; when both happen in the same cycle, inflight(N) is unchanged.
REQ-021 SHALL pop FIFO[N] on rspN_valid & rspN_ready; rspN_data SHALL show the head entry and hold it stable while rspN_valid is high and rspN_ready is low.
REQ-022 SHALL, on a simultaneous FIFO write and pop for the same requester, perform both, leaving fifo_count unchanged; a write to an empty FIFO is not bypassed to the output.
REQ-023 SHALL return results to each requester in that requester's issue order; there is no ordering constraint between requesters.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-025 SHALL fill the pipeline back to back: with both requesters saturated and consumers always ready, one accept every cycle, alternating 0,1,0,1.

Reset
REQ-026 SHALL, on rst, clear all tags, inflight counters, FIFO pointers and counts; the pointer resets so requester 0 wins the first tie.
REQ-027 SHALL hold reqN_ready, rspN_valid and busy low during the rst cycle and in the first cycle after reset.
REQ-028 SHALL discard all in-flight multiplier outputs when rst is asserted mid-operation, because their tags are cleared.

Configuration
REQ-029 SHALL support macro FP16_ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins a tie and the pointer is unused; when undefined, round robin per REQ-015.

Verification
REQ-030 SHALL verify: req0 a=3C00 b=4000 accepted cycle C, rsp0_ready=1 -> rsp0_valid in C+6 with data 4000.
REQ-031 SHALL verify: both valid every cycle (req0 3E00*4000, req1 7C00*0000) -> grants alternate 0,1,…; rsp0_data=4200 and rsp1_data=7E00.
REQ-032 SHALL verify: rsp0_ready=0, req0 always valid -> exactly 8 accepts, then req0_ready stays low; after one pop, exactly one further accept.
REQ-033 SHALL verify: write and pop on the same FIFO in the same cycle while count=3 -> count stays 3 and data order is preserved.
REQ-034 SHALL verify: rst asserted with 4 ops in flight -> no rspN_valid for the following 10 cycles, and busy=0 after reset.
REQ-035 SHALL verify, with FP16_ARB_FIXED_PRIORITY_EN defined: both requesters continuously valid -> only requester 0 is granted until its credit reaches 0.
